// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready write port into a small FIFO, LSB-first serial frames.
// Define UART_TX_PARITY_EN to add a parity bit (sense chosen by PARITY_ODD).
module uart_tx_fifo #(
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned N_DATA     = 8,
  parameter int unsigned N_STOP     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          wvalid,
  input  logic [N_DATA-1:0]             wdata,
  output logic                          wready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned T    = FREQ / BAUDRATE;
  localparam int unsigned CntW = $clog2(T);
  localparam int unsigned BitW = $clog2(N_DATA);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(T - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(N_DATA - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(N_STOP - 1);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

  if (T < 2 || N_DATA < 5 || N_DATA > 9 || (N_STOP != 1 && N_STOP != 2) || PARITY_ODD > 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [N_DATA-1:0]     shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic [N_DATA-1:0]     mem_q [FIFO_DEPTH];
  logic [N_DATA-1:0]     mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]       level_q, level_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic push, pop, empty, cnt_last;
  logic [N_DATA-1:0] head;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign wready   = nrst & (level_q != LvlFull);
  assign push     = wvalid & wready;
  assign empty    = (level_q == '0);
  assign head     = mem_q[rptr_q];
  assign cnt_last = (cnt_q == CntLast);

  assign tx    = tx_q;
  assign level = level_q;
  assign busy  = (state_q != StIdle) | ~empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = (PARITY_ODD != 0) ? ~^head : ^head;
`endif
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        tx_d = shreg_q[0];
        if (cnt_last) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = par_q;
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            // Chain straight into the next start bit so buffered frames have no gap.
            if (!empty) begin
              pop     = 1'b1;
              shreg_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = (PARITY_ODD != 0) ? ~^head : ^head;
`endif
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      mem_q   <= mem_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with T=10, N_DATA=8: one even-parity/1-stop, one odd-parity
// and one 2-stop instance; frame expectations depend on whether UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  localparam int T = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NC1 = 1 + 8 + P + 1;
  localparam int NC2 = 1 + 8 + P + 2;

  logic       clk, nrst, wvalid, wvalid_s;
  logic [7:0] wdata, wdata_s;
  logic       wready_a, tx_a, busy_a, wready_o, tx_o, busy_o, wready_s, tx_s, busy_s;
  logic [2:0] level_a, level_o, level_s;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .N_DATA(8), .N_STOP(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .nrst(nrst), .wvalid(wvalid), .wdata(wdata), .wready(wready_a),
    .tx(tx_a), .busy(busy_a), .level(level_a));

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .N_DATA(8), .N_STOP(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(1)) u_dut_o (
    .clk(clk), .nrst(nrst), .wvalid(wvalid), .wdata(wdata), .wready(wready_o),
    .tx(tx_o), .busy(busy_o), .level(level_o));

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .N_DATA(8), .N_STOP(2),
                 .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut_s (
    .clk(clk), .nrst(nrst), .wvalid(wvalid_s), .wdata(wdata_s), .wready(wready_s),
    .tx(tx_s), .busy(busy_s), .level(level_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;
  vec_t vecs [4];

  function automatic logic tx_of(input int sel);
    if (sel == 0) return tx_a;
    else if (sel == 1) return tx_o;
    else return tx_s;
  endfunction

  // Cell 0 is the start bit; cells beyond data/parity default to stop (1).
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic par);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    if (P == 1) b[9] = par;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    @(negedge clk);
    wvalid = 1'b1;
    wdata  = d;
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic wait_fall(input int sel, input int bound, output int n);
    n = 1;
    while (tx_of(sel) !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (tx_of(sel) !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL start_timeout dut%0d: tx=%b after %0d cycles, required 0", sel, tx_of(sel), n);
    end
  endtask

  // Starts on the first cycle of a frame; every cycle of every cell is checked.
  task automatic check_frame(input int sel, input logic [15:0] exp, input int ncells,
                             input string nm);
    logic bad, act;
    for (int c = 0; c < ncells; c++) begin
      bad = 1'b0;
      act = exp[c];
      for (int t = 0; t < T; t++) begin
        if (c != 0 || t != 0) @(negedge clk);
        if (tx_of(sel) !== exp[c]) begin
          bad = 1'b1;
          act = tx_of(sel);
        end
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s dut%0d cell %0d: tx=%b, required %b", nm, sel, c, act, exp[c]);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, nacc;
    logic ok, bad;
    logic [7:0] d;

    vecs[0] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1};
    vecs[1] = '{data: 8'h07, par_even: 1'b1, par_odd: 1'b0};
    vecs[2] = '{data: 8'h00, par_even: 1'b0, par_odd: 1'b1};
    vecs[3] = '{data: 8'hFF, par_even: 1'b0, par_odd: 1'b1};

    nrst = 1'b0; wvalid = 1'b0; wdata = '0; wvalid_s = 1'b0; wdata_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx_a), 16'h1);
    chk("rst_wready", 16'(wready_a), 16'h0);
    chk("rst_busy", 16'(busy_a), 16'h0);
    chk("rst_level", 16'(level_a), 16'h0);
    nrst = 1'b1;
    @(negedge clk);
    chk("wready_after_rst", 16'(wready_a), 16'h1);

    for (int v = 0; v < 4; v++) begin
      d = vecs[v].data;
      push_one(d);
      chk("level_after_push", 16'(level_a), 16'h1);
      chk("busy_after_push", 16'(busy_a), 16'h1);
      wait_fall(0, 20, n);
      chk("start_latency", 16'(n), 16'd3);
      fork
        check_frame(0, frame_bits(d, vecs[v].par_even), NC1, "frame_even");
        check_frame(1, frame_bits(d, vecs[v].par_odd), NC1, "frame_odd");
      join
      chk("busy_end", 16'(busy_a), 16'h0);
      chk("level_end", 16'(level_a), 16'h0);
    end

    // FIFO fill: 8 offered words, 5 taken, five gapless frames.
    acc = 0;
    fork
      begin
        @(negedge clk);
        wvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wdata = 8'(i + 1);
          if (wready_a) acc++;
          @(negedge clk);
        end
        wvalid = 1'b0;
        chk("fill_accepted", 16'(acc), 16'd5);
        chk("fill_wready", 16'(wready_a), 16'h0);
      end
      begin
        wait_fall(0, 30, n);
        for (int f = 0; f < 5; f++) begin
          d = 8'(f + 1);
          fork
            check_frame(0, frame_bits(d, ^d), NC1, "fill_even");
            check_frame(1, frame_bits(d, ~^d), NC1, "fill_odd");
          join
          if (f < 4) @(negedge clk);
        end
        chk("fill_busy_end", 16'(busy_a), 16'h0);
      end
    join

    // Full boundary: pop edge must not take the waiting word; the next edge does.
    @(negedge clk);
    wvalid = 1'b1;
    wdata  = 8'h11;
    nacc   = 0;
    for (int c = 0; c < 20 && nacc < 5; c++) begin
      ok = wready_a;
      @(negedge clk);
      if (ok) begin
        nacc++;
        wdata = 8'h11 + 8'(nacc);
      end
    end
    wdata = 8'h5A;
    chk("full_level", 16'(level_a), 16'd4);
    chk("full_wready", 16'(wready_a), 16'h0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (level_a != 3'd4) break;
    end
    chk("pop_edge_level", 16'(level_a), 16'd3);
    chk("pop_edge_wready", 16'(wready_a), 16'h1);
    @(negedge clk);
    chk("next_edge_level", 16'(level_a), 16'd4);
    wvalid = 1'b0;
    for (int c = 0; c < 1000 && busy_a; c++) @(negedge clk);
    chk("drain_busy", 16'(busy_a), 16'h0);

    // Two stop bits, back-to-back.
    @(negedge clk);
    wvalid_s = 1'b1;
    wdata_s  = 8'hFF;
    @(negedge clk);
    wdata_s  = 8'h00;
    @(negedge clk);
    wvalid_s = 1'b0;
    wait_fall(2, 20, n);
    check_frame(2, frame_bits(8'hFF, 1'b0), NC2, "stop2_first");
    @(negedge clk);
    check_frame(2, frame_bits(8'h00, 1'b0), NC2, "stop2_second");

    // Reset 35 cycles into a frame with two words queued.
    @(negedge clk);
    wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'h3C + 8'(i);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wait_fall(0, 20, n);
    repeat (35) @(negedge clk);
    chk("pre_rst_level", 16'(level_a), 16'd2);
    nrst = 1'b0;
    #1;
    chk("midrst_tx", 16'(tx_a), 16'h1);
    chk("midrst_level", 16'(level_a), 16'h0);
    chk("midrst_busy", 16'(busy_a), 16'h0);
    chk("midrst_wready", 16'(wready_a), 16'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) bad = 1'b1;
    end
    chk("post_rst_tx_quiet", 16'(bad), 16'h0);
    chk("post_rst_busy", 16'(busy_a), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter. It is the next-generation replacement for the single-word serialiser on the ADC readout path. It accepts data words through a valid/ready handshake into an internal FIFO and emits asynchronous serial frames (LSB first) back-to-back. Data width, stop-bit count, FIFO depth and optional parity are configurable. It sits between the temperature/ADC result formatter and the board-level UART pin.

## Interface
- FREQ, 50_000_000, system clock frequency in Hz
- BAUDRATE, 115200, serial bit rate; T = FREQ/BAUDRATE (integer division) clocks per bit, T ≥ 2
- N_DATA, 8, data bits per frame, legal 5..9
- N_STOP, 1, stop bits, legal 1 or 2
- FIFO_DEPTH, 4, FIFO entries, power of 2, ≥ 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN)
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous, active-low reset
- wvalid  input  1  write request; word accepted on an edge where wvalid & wready
- wdata  input  N_DATA  word to transmit
- wready  output  1  FIFO not full
- tx  output  1  serial line, idle high, registered
- busy  output  1  high while a frame is in progress or the FIFO is non-empty
- level  output  $clog2(FIFO_DEPTH)+1  number of words stored in the FIFO, excluding the frame being shifted

## Operation
- Reset values: tx=1, wready=0 while nrst low and 1 after release, busy=0, level=0. FIFO pointers, FSM state and counters are cleared.
- FIFO: wready = (level != FIFO_DEPTH). A push is blocked when full, even if a pop occurs on the same edge. A simultaneous push and pop when not full leaves level unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when FIFO non-empty. The head word is popped into the shift register on that edge.
  - START→DATA after T cycles.
  - DATA→PARITY after N_DATA·T cycles if parity is enabled; otherwise DATA→STOP.
  - PARITY→STOP after T cycles.
  - STOP→START directly if the FIFO is non-empty at the last STOP cycle (pop on the same edge); otherwise STOP→IDLE. STOP lasts N_STOP·T cycles.
- Bit values:
  - start bit = 0
  - data bits = wdata[0] first, up to wdata[N_DATA-1]
  - parity bit = ^data for even parity, ~^data for odd parity
  - stop bits = 1
- Counters: clock counter counts 0..T-1, width $clog2(T). Bit counter counts 0..N_DATA-1 in DATA and 0..N_STOP-1 in STOP. No other state uses it.
- A data word is frozen in the shift register at pop time; later FIFO activity does not affect the frame in flight.
- Reset mid-frame: tx returns to 1 asynchronously, the frame is abandoned, and the FIFO is flushed. Nothing is emitted after release until a new push.

## Timing
- Latency: for a push accepted at edge k into an idle, empty block, the pop happens at edge k+1 and tx falls after edge k+2. It stays low for exactly T cycles.
- Frame length is (1 + N_DATA + P + N_STOP)·T cycles, where P = 1 with parity and 0 without.
- Consecutive buffered frames have zero idle cycles between the last stop bit and the next start bit.
- busy rises the cycle after the first accepted push. It falls the cycle after the final stop bit ends with the FIFO empty.
- level updates on the edge after a push or pop.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state and parity bit are present, and PARITY_ODD selects the parity sense.
- UART_TX_PARITY_EN undefined: there is no parity logic, frames carry no parity bit, and PARITY_ODD is ignored.

## Test plan
All scenarios use FREQ=1_000_000, BAUDRATE=100_000 (T=10), N_DATA=8.
- Single frame: push 0xA5, parity off, N_STOP=1 → tx bits 0,1,0,1,0,0,1,0,1,1, each 10 cycles long (100 cycles total). busy then drops and level=0.
- Parity: UART_TX_PARITY_EN defined, push 0x07. With PARITY_ODD=0 the parity bit is 1; with PARITY_ODD=1 it is 0. Frame is 110 cycles.
- FIFO fill: FIFO_DEPTH=4, hold wvalid for 8 cycles with wdata=0x01..0x08 → exactly 0x01–0x05 accepted and wready falls. Five frames follow back-to-back in 500 cycles with no idle cycles, data in order.
- Full-boundary: FIFO full and the current frame's last stop cycle coincides with wvalid=1 → the word is not accepted on that edge. It is accepted on the next edge (wready=1, level 3→4).
- Two stop bits: N_STOP=2, push 0xFF then 0x00 → tx high for 20 cycles of stop before the second start bit.
- Reset mid-frame: assert nrst low 35 cycles into a frame with 2 words queued → tx=1 immediately, level=0, busy=0. After release tx stays 1 for 200 cycles.
